// File: rtl/rcc_pclk_cfg_seq.sv
// Purpose : walks APB prescaler (div_sel) / timer prescaler (timpre) changes one ratio step
//           at a time, each step aligned to a divider boundary and followed by a settle time.
// Latency : no-op request completes (done) one cycle after accept; otherwise the first step
//           is visible two cycles after accept at the earliest.
// Backpressure: cfg_ready is high only in IDLE; cfg_valid while busy is dropped, not queued.
// Ports:
//   i_clk, rst          clock and synchronous active-high reset
//   cfg_valid/cfg_ready request handshake; cfg_div_sel/cfg_timpre are sampled at accept
//   div_en              divider boundary pulse used to align each step
//   div_sel, timpre     registered outputs driving the pclk/timer divider
//   busy, done          sequence in progress / one-cycle completion pulse
//   align_err           sticky flag: a step of the current/last sequence was forced by timeout
module rcc_pclk_cfg_seq #(
    parameter int         SETTLE_CYC    = 4,
    parameter int         ALIGN_TIMEOUT = 32,
    parameter logic [2:0] RST_DIV_SEL   = 3'b000,
    parameter logic       RST_TIMPRE    = 1'b0
) (
    input  logic       i_clk,
    input  logic       rst,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [2:0] cfg_div_sel,
    input  logic       cfg_timpre,
    input  logic       div_en,
    output logic [2:0] div_sel,
    output logic       timpre,
    output logic       busy,
    output logic       done,
    output logic       align_err
);

    localparam int WAIT_W = $clog2(ALIGN_TIMEOUT) + 1;
    localparam int SET_W  = $clog2(SETTLE_CYC) + 1;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ALIGN_TIMEOUT - 1);
    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYC - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ALIGN  = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // Ratio level of a prescaler code: 0xx is /1 (level 0), 1nn is level nn+1.
    function automatic logic [2:0] lvl_of(input logic [2:0] code);
        return code[2] ? ({1'b0, code[1:0]} + 3'd1) : 3'd0;
    endfunction

    // Canonical code for an intermediate level; level 0 maps to 011.
    function automatic logic [2:0] code_of(input logic [2:0] lvl);
        return (lvl == 3'd0) ? 3'b011 : {1'b1, 2'(lvl - 3'd1)};
    endfunction

    logic [1:0]        state;
    logic [2:0]        tgt_sel;
    logic              tgt_tp;
    logic [WAIT_W-1:0] wait_cnt;
    logic [SET_W-1:0]  set_cnt;

    logic [2:0] cur_lvl;
    logic [2:0] tgt_lvl;
    logic [2:0] nxt_lvl;
    logic       step_final;
    logic       step_fire;
    logic       at_target;
    logic       req_noop;

    always_comb begin
        cur_lvl = lvl_of(div_sel);
        tgt_lvl = lvl_of(tgt_sel);
        nxt_lvl = cur_lvl;
        if (tgt_lvl > cur_lvl) begin
            nxt_lvl = cur_lvl + 3'd1;
        end else if (tgt_lvl < cur_lvl) begin
            nxt_lvl = cur_lvl - 3'd1;
        end
    end

    assign step_final = (nxt_lvl == tgt_lvl);
    assign step_fire  = div_en || (wait_cnt == WAIT_LAST);
    // Completion compares ratio level, so a timpre-only sequence (raw 0xx code kept) ends.
    assign at_target  = (cur_lvl == tgt_lvl) && (timpre == tgt_tp);
    assign req_noop   = (lvl_of(cfg_div_sel) == cur_lvl) && (cfg_timpre == timpre);

    assign cfg_ready = (state == S_IDLE);
    assign busy      = ~cfg_ready;
    assign done      = (state == S_DONE);

    always_ff @(posedge i_clk) begin
        if (rst) begin
            state     <= S_IDLE;
            div_sel   <= RST_DIV_SEL;
            timpre    <= RST_TIMPRE;
            tgt_sel   <= RST_DIV_SEL;
            tgt_tp    <= RST_TIMPRE;
            wait_cnt  <= '0;
            set_cnt   <= '0;
            align_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        tgt_sel   <= cfg_div_sel;
                        tgt_tp    <= cfg_timpre;
                        align_err <= 1'b0;
                        wait_cnt  <= '0;
                        set_cnt   <= '0;
                        state     <= req_noop ? S_DONE : S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    if (step_fire) begin
                        // Level-changing step; a timpre-only step leaves div_sel alone.
                        if (cur_lvl != tgt_lvl) begin
                            div_sel <= step_final ? tgt_sel : code_of(nxt_lvl);
                        end
                        if (step_final) begin
                            timpre <= tgt_tp;
                        end
                        if (!div_en) begin
                            align_err <= 1'b1;
                        end
                        wait_cnt <= '0;
                        set_cnt  <= '0;
                        state    <= S_SETTLE;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (set_cnt == SET_LAST) begin
                        set_cnt  <= '0;
                        wait_cnt <= '0;
                        state    <= at_target ? S_DONE : S_ALIGN;
                    end else if (set_cnt != '1) begin
                        set_cnt <= set_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rcc_pclk_cfg_seq.sv
// Purpose : self-checking bench for rcc_pclk_cfg_seq using a transaction-level timeline model.
// Latency : model predicts every output for every cycle of each request from the div_en pattern.
// Backpressure: cfg_valid is toggled randomly while busy; those requests must be dropped.
module tb_rcc_pclk_cfg_seq;

    localparam int S  = 4;
    localparam int TO = 32;

    logic       clk;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] cfg_div_sel;
    logic       cfg_timpre;
    logic       div_en;
    logic [2:0] div_sel;
    logic       timpre;
    logic       busy;
    logic       done;
    logic       align_err;

    int checks = 0;
    int errors = 0;
    int n_req  = 0;

    // Reference state: applied code, applied timpre, sticky error flag.
    logic [2:0] m_sel;
    logic       m_tp;
    logic       m_aerr;

    rcc_pclk_cfg_seq #(
        .SETTLE_CYC   (S),
        .ALIGN_TIMEOUT(TO),
        .RST_DIV_SEL  (3'b000),
        .RST_TIMPRE   (1'b0)
    ) dut (
        .i_clk      (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_div_sel(cfg_div_sel),
        .cfg_timpre (cfg_timpre),
        .div_en     (div_en),
        .div_sel    (div_sel),
        .timpre     (timpre),
        .busy       (busy),
        .done       (done),
        .align_err  (align_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic int lv(input logic [2:0] c);
        return (c < 3'd4) ? 0 : int'(c) - 3;
    endfunction

    function automatic logic [7:0] obs_vec();
        return {cfg_ready, busy, done, align_err, timpre, div_sel};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b (ready,busy,done,aerr,timpre,sel)", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 random sparse div_en, 1 pulse every 3 cycles, 2 never, 3 always.
    task automatic run_req(input logic [2:0] tgt, input logic tp, input int mode);
        bit         de [0:255];
        logic [2:0] es [0:255];
        logic       et [0:255];
        logic       ed [0:255];
        logic       er [0:255];
        logic       ea [0:255];
        logic [2:0] codes[$];
        int         cl, tl, dir, c, s, last;
        bit         forced;

        for (int k = 0; k < 256; k++) begin
            case (mode)
                0:       de[k] = ($urandom_range(0, 3) == 0);
                1:       de[k] = (k % 3 == 1);
                2:       de[k] = 1'b0;
                default: de[k] = 1'b1;
            endcase
            es[k] = m_sel;
            et[k] = m_tp;
            ed[k] = 1'b0;
            er[k] = 1'b0;
            ea[k] = (k == 0) ? m_aerr : 1'b0;
        end
        er[0] = 1'b1;

        cl  = lv(m_sel);
        tl  = lv(tgt);
        dir = (tl > cl) ? 1 : -1;
        if (cl == tl && tp != m_tp) begin
            codes.push_back(m_sel);
        end else begin
            for (int l = cl; l != tl; l += dir) begin
                codes.push_back(((l + dir) == tl) ? tgt : 3'(l + dir + 3));
            end
        end

        if (codes.size() == 0) begin
            ed[1] = 1'b1;
            last  = 2;
        end else begin
            s = 1;
            for (int i = 0; i < codes.size(); i++) begin
                c = s;
                while (!(de[c] || c == s + TO - 1)) c++;
                forced = !de[c];
                for (int k = c + 1; k < 256; k++) begin
                    es[k] = codes[i];
                    if (i == codes.size() - 1) et[k] = tp;
                    if (forced) ea[k] = 1'b1;
                end
                s = c + S + 1;
            end
            ed[s] = 1'b1;
            last  = s + 1;
        end
        er[last] = 1'b1;

        for (int k = 0; k <= last; k++) begin
            if (k == 0) begin
                cfg_valid   = 1'b1;
                cfg_div_sel = tgt;
                cfg_timpre  = tp;
            end else begin
                cfg_valid   = (k < last) ? 1'($urandom_range(0, 1)) : 1'b0;
                cfg_div_sel = 3'($urandom_range(0, 7));
                cfg_timpre  = 1'($urandom_range(0, 1));
            end
            div_en = de[k];
            check($sformatf("req%0d tgt%b tp%b mode%0d cyc%0d", n_req, tgt, tp, mode, k),
                  obs_vec(), {er[k], ~er[k], ed[k], ea[k], et[k], es[k]});
            if (k < last) tick();
        end
        m_sel  = es[last];
        m_tp   = et[last];
        m_aerr = ea[last];
        n_req++;
    endtask

    initial begin
        rst         = 1'b1;
        cfg_valid   = 1'b0;
        cfg_div_sel = 3'b000;
        cfg_timpre  = 1'b0;
        div_en      = 1'b0;

        // Reset for two cycles, then release and check reset values.
        tick();
        tick();
        rst = 1'b0;
        check("reset_state", obs_vec(), 8'b1000_0000);
        m_sel  = 3'b000;
        m_tp   = 1'b0;
        m_aerr = 1'b0;

        // 000 -> 111 with div_en every third cycle.
        run_req(3'b111, 1'b0, 1);
        // 111 -> 110, then 110 -> 001 with timpre rising on the final step.
        run_req(3'b110, 1'b0, 0);
        run_req(3'b001, 1'b1, 1);
        // Reach 010, then a same-level request is a no-op.
        run_req(3'b100, 1'b0, 3);
        run_req(3'b010, 1'b0, 3);
        run_req(3'b000, 1'b0, 0);
        // div_en held low: step forced by timeout, align_err set; next accept clears it.
        run_req(3'b100, 1'b0, 2);
        run_req(3'b000, 1'b0, 3);

        // Reset during SETTLE of 000 -> 111.
        cfg_valid   = 1'b1;
        cfg_div_sel = 3'b111;
        cfg_timpre  = 1'b0;
        div_en      = 1'b1;
        check("rst_mid_accept", obs_vec(), 8'b1000_0000);
        tick();
        cfg_div_sel = 3'b010;
        tick();
        check("rst_mid_settle", obs_vec(), 8'b0100_0100);
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        cfg_valid = 1'b0;
        check("rst_mid_after", obs_vec(), 8'b1000_0000);
        for (int k = 0; k < S + 3; k++) begin
            tick();
            check($sformatf("rst_mid_quiet%0d", k), obs_vec(), 8'b1000_0000);
        end
        m_sel  = 3'b000;
        m_tp   = 1'b0;
        m_aerr = 1'b0;

        // Random requests with random div_en patterns.
        for (int r = 0; r < 24; r++) begin
            run_req(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
